// File: rtl/hex_word_ascii_streamer_if.sv
// hex_word_ascii_streamer_if: word-in / ASCII-char-out handshake bundle
interface hex_word_ascii_streamer_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] In_Data;
  logic In_Lower;
  logic In_Valid;
  logic In_Ready;
  logic [7:0] Out_Char;
  logic Out_Valid;
  logic Out_Ready;
  logic Busy;
  modport master (output In_Data, In_Lower, In_Valid, Out_Ready, input In_Ready, Out_Char, Out_Valid, Busy);
  modport slave (input In_Data, In_Lower, In_Valid, Out_Ready, output In_Ready, Out_Char, Out_Valid, Busy);
endinterface

// File: rtl/hex_word_ascii_streamer.sv
// hex_word_ascii_streamer: streams a binary word as ASCII hex, MS nibble first, optional CR/LF
module hex_word_ascii_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter bit APPEND_EOL = 1'b1
) (
  input logic Clk,
  input logic Rst_N,
  hex_word_ascii_streamer_if.slave bus
);
  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  typedef enum logic [1:0] {IDLE, DIGIT, CR, LF} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] word;
  logic lower;
  if (DATA_WIDTH % 4 != 0 || DATA_WIDTH < 4) begin : g_bad_width
    $error("hex_word_ascii_streamer: DATA_WIDTH must be a positive multiple of 4");
  end
  function automatic logic [7:0] ascii(input logic [3:0] n, input logic lc);
    return n <= 4'd9 ? 8'h30 + {4'h0, n} : (lc ? 8'h57 : 8'h37) + {4'h0, n};
  endfunction
  assign bus.In_Ready = state == IDLE;
  assign bus.Busy = state != IDLE;
  // Out_Valid is high in every non-IDLE state, so Out_Ready alone marks a transfer there.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state <= IDLE;
      idx <= '0;
      word <= '0;
      lower <= 1'b0;
      bus.Out_Valid <= 1'b0;
      bus.Out_Char <= 8'h00;
    end else if (state == IDLE) begin
      if (bus.In_Valid) begin
        word <= bus.In_Data;
        lower <= bus.In_Lower;
        idx <= IW'(NIBBLES - 1);
        state <= DIGIT;
        bus.Out_Valid <= 1'b1;
        bus.Out_Char <= ascii(bus.In_Data[DATA_WIDTH-1 -: 4], bus.In_Lower);
      end
    end else if (bus.Out_Ready) begin
      case (state)
        DIGIT:
          if (idx != '0) begin
            idx <= idx - 1'b1;
            bus.Out_Char <= ascii(word[4*(int'(idx)-1) +: 4], lower);
          end else if (APPEND_EOL) begin
            state <= CR;
            bus.Out_Char <= 8'h0D;
          end else begin
            state <= IDLE;
            bus.Out_Valid <= 1'b0;
          end
        CR: begin
          state <= LF;
          bus.Out_Char <= 8'h0A;
        end
        default: begin
          state <= IDLE;
          bus.Out_Valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
